mat_reg_file: RTL and testbench

MAT_REG_FILE -- requirements
Module: mat_reg_file

---
 rtl/mat_pkg.sv | 35 +++
 rtl/mat_reg_file_if.sv | 38 +++
 rtl/mat_bank.sv | 102 ++++++++++
 rtl/mat_reg_file.sv | 185 ++++++++++++++++++
 tb/tb_mat_reg_file.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mat_pkg.sv
//============================================================================
// Module : mat_pkg
// Shared matrix operation codes and FSM state encodings for mat_reg_file.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

package mat_pkg;

    typedef enum logic [3:0] {
        NOP,
        ZERO,
        WR_ROW,
        WR_COL,
        WR_SCALAR,
        WR_DIAG,
        RD_ROW,
        RD_COL,
        RD_SCALAR,
        RD_DIAG,
        XFLIP,
        YFLIP,
        COPY,
        XPOSE
    } MatRegOp_t;

    typedef logic [1:0] mat_state_t;

    localparam mat_state_t c_ST_IDLE  = 2'd0;
    localparam mat_state_t c_ST_COPY  = 2'd1;
    localparam mat_state_t c_ST_XPOSE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mat_reg_file_if.sv
//============================================================================
// Module : mat_reg_file_if
// Operation request / read response bundle for mat_reg_file.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

interface mat_reg_file_if #(
    parameter int WIDTH    = 16,
    parameter int DATA_W   = 32,
    parameter int NUM_MATS = 4
);
    import mat_pkg::*;

    logic                                op_valid;
    logic                                op_ready;
    MatRegOp_t                           op_code;
    logic [$clog2(NUM_MATS)-1:0]         op_mat;
    logic [$clog2(NUM_MATS)-1:0]         op_src;
    logic [$clog2(WIDTH):0]              op_param1;
    logic [$clog2(WIDTH):0]              op_param2;
    logic [WIDTH-1:0][DATA_W-1:0]        data_in;
    logic [WIDTH-1:0][DATA_W-1:0]        data_out;
    logic                                out_valid;

    modport master (
        output op_valid, op_code, op_mat, op_src, op_param1, op_param2, data_in,
        input  op_ready, data_out, out_valid
    );

    modport slave (
        input  op_valid, op_code, op_mat, op_src, op_param1, op_param2, data_in,
        output op_ready, data_out, out_valid
    );

endinterface

`default_nettype wire

// File: rtl/mat_bank.sv
//============================================================================
// Module : mat_bank
// One WIDTH x WIDTH matrix: storage, single-cycle writes, read muxes.
// Diagonal ports exist only with MAT_REG_FILE_DIAG_EN defined.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module mat_bank
    import mat_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DATA_W = 32,
    localparam int IW     = $clog2(WIDTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_wr_en,
    input  MatRegOp_t                    i_wr_op,
    input  logic [IW-1:0]                i_wr_p1,
    input  logic [IW-1:0]                i_wr_p2,
    input  logic [WIDTH-1:0][DATA_W-1:0] i_wr_data,
    input  logic [IW-1:0]                i_rd_p1,
    input  logic [IW-1:0]                i_rd_p2,
    output logic [WIDTH-1:0][DATA_W-1:0] o_rd_row,
    output logic [WIDTH-1:0][DATA_W-1:0] o_rd_col,
`ifdef MAT_REG_FILE_DIAG_EN
    output logic [WIDTH-1:0][DATA_W-1:0] o_rd_diag,
`endif
    output logic [DATA_W-1:0]            o_rd_scalar
);

    logic [DATA_W-1:0] r_mem [WIDTH][WIDTH];

    assign o_rd_scalar = r_mem[i_rd_p1][i_rd_p2];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
`ifdef MAT_REG_FILE_DIAG_EN
        // Wrapped anti-diagonal: row gi pairs with column (p1 - gi) mod WIDTH
        logic [IW-1:0] w_wr_dcol;
        logic [IW-1:0] w_rd_dcol;
        assign w_wr_dcol     = i_wr_p1 - IW'(gi);
        assign w_rd_dcol     = i_rd_p1 - IW'(gi);
        assign o_rd_diag[gi] = r_mem[gi][w_rd_dcol];
`endif
        assign o_rd_row[gi] = r_mem[i_rd_p1][gi];
        assign o_rd_col[gi] = r_mem[gi][i_rd_p1];

        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_elem
            logic              w_we;
            logic [DATA_W-1:0] w_d;

            always_comb begin
                w_we = 1'b0;
                w_d  = '0;
                if (i_wr_en) begin
                    case (i_wr_op)
                        ZERO: w_we = 1'b1;
                        WR_ROW: begin
                            w_we = (i_wr_p1 == IW'(gi));
                            w_d  = i_wr_data[gj];
                        end
                        WR_COL: begin
                            w_we = (i_wr_p1 == IW'(gj));
                            w_d  = i_wr_data[gi];
                        end
                        WR_SCALAR: begin
                            w_we = (i_wr_p1 == IW'(gi)) && (i_wr_p2 == IW'(gj));
                            w_d  = i_wr_data[0];
                        end
`ifdef MAT_REG_FILE_DIAG_EN
                        WR_DIAG: begin
                            w_we = (w_wr_dcol == IW'(gj));
                            w_d  = i_wr_data[gi];
                        end
`endif
                        XFLIP: begin
                            w_we = 1'b1;
                            w_d  = r_mem[WIDTH-1-gi][gj];
                        end
                        YFLIP: begin
                            w_we = 1'b1;
                            w_d  = r_mem[gi][WIDTH-1-gj];
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_mem[gi][gj] <= '0;
                end else if (w_we) begin
                    r_mem[gi][gj] <= w_d;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mat_reg_file.sv
//============================================================================
// Module : mat_reg_file
// NUM_MATS matrix register file with row-streamed COPY/XPOSE FSM.
// Define MAT_REG_FILE_DIAG_EN to enable WR_DIAG / RD_DIAG.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module mat_reg_file
    import mat_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DATA_W   = 32,
    parameter int NUM_MATS = 4
) (
    input  logic           clock,
    input  logic           reset,
    mat_reg_file_if.slave  bus
);

    localparam int            IW         = $clog2(WIDTH);
    localparam int            MW         = $clog2(NUM_MATS);
    localparam logic [IW-1:0] c_LAST_ROW = IW'(WIDTH - 1);

    mat_state_t                   r_state;
    logic [IW-1:0]                r_row;
    logic [MW-1:0]                r_src;
    logic [MW-1:0]                r_dst;
    logic                         r_out_valid;
    logic [WIDTH-1:0][DATA_W-1:0] r_data_out;

    logic [WIDTH-1:0][DATA_W-1:0] w_bank_row    [NUM_MATS];
    logic [WIDTH-1:0][DATA_W-1:0] w_bank_col    [NUM_MATS];
    logic [DATA_W-1:0]            w_bank_scalar [NUM_MATS];
`ifdef MAT_REG_FILE_DIAG_EN
    logic [WIDTH-1:0][DATA_W-1:0] w_bank_diag   [NUM_MATS];
`endif

    logic                         w_busy;
    logic                         w_accept;
    logic                         w_p1_ok;
    logic                         w_p2_ok;
    logic                         w_mat_ok;
    logic                         w_src_ok;
    logic [NUM_MATS-1:0]          w_we;
    MatRegOp_t                    w_wr_op;
    logic [IW-1:0]                w_wr_p1;
    logic [IW-1:0]                w_wr_p2;
    logic [WIDTH-1:0][DATA_W-1:0] w_wr_data;
    logic [IW-1:0]                w_rd_p1;
    logic                         w_is_read;
    logic [WIDTH-1:0][DATA_W-1:0] w_rd_result;

    assign w_busy        = (r_state != c_ST_IDLE);
    assign bus.op_ready  = !w_busy;
    assign w_accept      = bus.op_valid && !w_busy;
    assign w_p1_ok       = !bus.op_param1[IW];
    assign w_p2_ok       = !bus.op_param2[IW];
    assign w_rd_p1       = w_busy ? r_row : bus.op_param1[IW-1:0];
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;

    if (NUM_MATS == (1 << MW)) begin : g_mat_pow2
        assign w_mat_ok = 1'b1;
        assign w_src_ok = 1'b1;
    end else begin : g_mat_partial
        assign w_mat_ok = (32'(bus.op_mat) < 32'(NUM_MATS));
        assign w_src_ok = (32'(bus.op_src) < 32'(NUM_MATS));
    end

    for (genvar gm = 0; gm < NUM_MATS; gm++) begin : g_bank
        mat_bank #(
            .WIDTH  (WIDTH),
            .DATA_W (DATA_W)
        ) u_bank (
            .clock       (clock),
            .reset       (reset),
            .i_wr_en     (w_we[gm]),
            .i_wr_op     (w_wr_op),
            .i_wr_p1     (w_wr_p1),
            .i_wr_p2     (w_wr_p2),
            .i_wr_data   (w_wr_data),
            .i_rd_p1     (w_rd_p1),
            .i_rd_p2     (bus.op_param2[IW-1:0]),
            .o_rd_row    (w_bank_row[gm]),
            .o_rd_col    (w_bank_col[gm]),
`ifdef MAT_REG_FILE_DIAG_EN
            .o_rd_diag   (w_bank_diag[gm]),
`endif
            .o_rd_scalar (w_bank_scalar[gm])
        );
    end

    // While streaming, the destination bank takes one row per cycle from the source bank
    always_comb begin
        w_we      = '0;
        w_wr_op   = bus.op_code;
        w_wr_p1   = bus.op_param1[IW-1:0];
        w_wr_p2   = bus.op_param2[IW-1:0];
        w_wr_data = bus.data_in;
        if (w_busy) begin
            w_we[r_dst] = 1'b1;
            w_wr_op     = WR_ROW;
            w_wr_p1     = r_row;
            w_wr_data   = (r_state == c_ST_COPY) ? w_bank_row[r_src] : w_bank_col[r_src];
        end else if (w_accept && w_mat_ok) begin
            case (bus.op_code)
                ZERO, XFLIP, YFLIP: w_we[bus.op_mat] = 1'b1;
                WR_ROW, WR_COL:     w_we[bus.op_mat] = w_p1_ok;
                WR_SCALAR:          w_we[bus.op_mat] = w_p1_ok && w_p2_ok;
`ifdef MAT_REG_FILE_DIAG_EN
                WR_DIAG:            w_we[bus.op_mat] = w_p1_ok;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        w_is_read   = 1'b0;
        w_rd_result = '0;
        case (bus.op_code)
            RD_ROW: begin
                w_is_read = 1'b1;
                if (w_mat_ok && w_p1_ok) w_rd_result = w_bank_row[bus.op_mat];
            end
            RD_COL: begin
                w_is_read = 1'b1;
                if (w_mat_ok && w_p1_ok) w_rd_result = w_bank_col[bus.op_mat];
            end
            RD_SCALAR: begin
                w_is_read = 1'b1;
                if (w_mat_ok && w_p1_ok && w_p2_ok) w_rd_result[0] = w_bank_scalar[bus.op_mat];
            end
            RD_DIAG: begin
                w_is_read = 1'b1;
`ifdef MAT_REG_FILE_DIAG_EN
                if (w_mat_ok && w_p1_ok) w_rd_result = w_bank_diag[bus.op_mat];
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_row       <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_out_valid <= w_accept && w_is_read;
            if (w_accept && w_is_read) begin
                r_data_out <= w_rd_result;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && w_mat_ok && w_src_ok) begin
                        r_src <= bus.op_src;
                        r_dst <= bus.op_mat;
                        r_row <= '0;
                        if (bus.op_code == COPY) begin
                            r_state <= c_ST_COPY;
                        end else if (bus.op_code == XPOSE && bus.op_src != bus.op_mat) begin
                            r_state <= c_ST_XPOSE;
                        end
                    end
                end
                default: begin
                    if (r_row == c_LAST_ROW) begin
                        r_state <= c_ST_IDLE;
                        r_row   <= '0;
                    end else begin
                        r_row <= r_row + IW'(1);
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mat_reg_file.sv
//============================================================================
// Module : tb_mat_reg_file
// Scoreboard bench for mat_reg_file (WIDTH=16, DATA_W=32, NUM_MATS=4).
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mat_reg_file;
    import mat_pkg::*;

    localparam int WIDTH    = 16;
    localparam int DATA_W   = 32;
    localparam int NUM_MATS = 4;

    typedef logic [WIDTH-1:0][DATA_W-1:0] vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mat_reg_file_if #(.WIDTH(WIDTH), .DATA_W(DATA_W), .NUM_MATS(NUM_MATS)) bus ();

    mat_reg_file #(.WIDTH(WIDTH), .DATA_W(DATA_W), .NUM_MATS(NUM_MATS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    vec_t exp_q[$];
    vec_t mon_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(negedge clock) begin
        if (!reset && bus.out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected: out_valid=1 with no read pending, data %h", bus.data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.data_out === mon_exp) n_pass++;
                else $display("FAIL rd_data: got %h expected %h", bus.data_out, mon_exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic issue(input MatRegOp_t c, input int m, input int s, input int p1,
                         input int p2, input vec_t d, output int waited);
        bus.op_valid  = 1'b1;
        bus.op_code   = c;
        bus.op_mat    = 2'(m);
        bus.op_src    = 2'(s);
        bus.op_param1 = 5'(p1);
        bus.op_param2 = 5'(p2);
        bus.data_in   = d;
        waited = 0;
        while (!bus.op_ready && waited < 100) begin
            @(posedge clock); #1;
            waited++;
        end
        if (waited >= 100) begin
            n_checks++;
            $display("FAIL issue_timeout: op_ready stayed 0 for %0d cycles, required 1", waited);
        end
        @(posedge clock); #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic op(input MatRegOp_t c, input int m, input int s, input int p1,
                      input int p2, input vec_t d);
        int w;
        issue(c, m, s, p1, p2, d, w);
    endtask

    task automatic rd(input MatRegOp_t c, input int m, input int p1, input int p2, input vec_t e);
        exp_q.push_back(e);
        op(c, m, 0, p1, p2, '0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.op_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   n;

        bus.op_valid  = 1'b0;
        bus.op_code   = NOP;
        bus.op_mat    = '0;
        bus.op_src    = '0;
        bus.op_param1 = '0;
        bus.op_param2 = '0;
        bus.data_in   = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        chk("rst_op_ready", 32'(bus.op_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_data_out_zero", 32'(bus.data_out == '0), 1);

        // Row write / read-back
        for (int j = 0; j < WIDTH; j++) v[j] = 32'(j + 1);
        op(WR_ROW, 1, 0, 3, 0, v);
        rd(RD_ROW, 1, 3, 0, v);

        // Fill mat0 with 16*i+j, transpose into mat2
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) v[j] = 32'(16 * i + j);
            op(WR_ROW, 0, 0, i, 0, v);
        end
        op(XPOSE, 2, 0, 0, 0, '0);
        wait_ready(n);
        chk("xpose_busy_cycles", 32'(n), 16);
        for (int j = 0; j < WIDTH; j++) e[j] = 32'(16 * j + 5);
        rd(RD_ROW, 2, 5, 0, e);
        for (int j = 0; j < WIDTH; j++) e[j] = 32'(80 + j);
        rd(RD_ROW, 0, 5, 0, e);
        for (int i = 0; i < WIDTH; i++) e[i] = 32'(16 * i + 2);
        rd(RD_COL, 0, 2, 0, e);
        e = '0; e[0] = 32'd115;
        rd(RD_SCALAR, 2, 3, 7, e);

        // In-place transpose is rejected
        op(XPOSE, 2, 2, 0, 0, '0);
        chk("xpose_inplace_ready", 32'(bus.op_ready), 1);
        for (int j = 0; j < WIDTH; j++) e[j] = 32'(16 * j + 5);
        rd(RD_ROW, 2, 5, 0, e);

        // Flips: mat2 row10 <- old row5; mat0[i][j] becomes 16*i+15-j
        op(XFLIP, 2, 0, 0, 0, '0);
        rd(RD_ROW, 2, 10, 0, e);
        op(YFLIP, 0, 0, 0, 0, '0);
        for (int j = 0; j < WIDTH; j++) e[j] = 32'(31 - j);
        rd(RD_ROW, 0, 1, 0, e);

        // COPY mat0->mat1 while a ZERO of the source is held pending
        op(COPY, 1, 0, 0, 0, '0);
        issue(ZERO, 0, 0, 0, 0, '0, n);
        chk("copy_busy_cycles", 32'(n), 16);
        for (int j = 0; j < WIDTH; j++) e[j] = 32'(255 - j);
        rd(RD_ROW, 1, 15, 0, e);
        for (int j = 0; j < WIDTH; j++) e[j] = 32'(15 - j);
        rd(RD_ROW, 1, 0, 0, e);
        rd(RD_ROW, 0, 3, 0, '0);

        // Reset in the middle of a COPY
        for (int j = 0; j < WIDTH; j++) v[j] = 32'hA5A5_0000 + 32'(j);
        op(WR_ROW, 0, 0, 0, 0, v);
        op(WR_ROW, 3, 0, 0, 0, v);
        op(COPY, 1, 0, 0, 0, '0);
        repeat (7) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 chk("midcopy_rst_idle", 32'(bus.op_ready), 1);
        reset = 1'b0;
        chk("midcopy_rst_ready", 32'(bus.op_ready), 1);
        chk("midcopy_rst_out_valid", 32'(bus.out_valid), 0);
        rd(RD_SCALAR, 0, 0, 0, '0);
        rd(RD_ROW, 3, 0, 0, '0);
        rd(RD_ROW, 1, 0, 0, '0);
        rd(RD_ROW, 1, 15, 0, '0);

        // Scalar write and out-of-range suppression
        v = '0; v[0] = 32'h55;
        op(WR_SCALAR, 0, 0, 2, 3, v);
        e = '0; e[0] = 32'h55;
        rd(RD_SCALAR, 0, 2, 3, e);
        v = '0; v[0] = 32'hDEAD;
        op(WR_SCALAR, 0, 0, 16, 3, v);
        rd(RD_ROW, 0, 0, 0, '0);
        e = '0; e[3] = 32'h55;
        rd(RD_ROW, 0, 2, 0, e);
        rd(RD_COL, 0, 20, 0, '0);
        rd(RD_COL, 0, 19, 0, '0);
        rd(RD_SCALAR, 0, 2, 19, '0);

        // Column write
        for (int i = 0; i < WIDTH; i++) v[i] = 32'(7 * i + 1);
        op(WR_COL, 1, 0, 4, 0, v);
        rd(RD_COL, 1, 4, 0, v);

        // Anti-diagonal: [0][2]=d0, [1][1]=d1, [2][0]=d2, [3][15]=d3
        for (int i = 0; i < WIDTH; i++) v[i] = 32'h100 + 32'(i);
        op(WR_DIAG, 3, 0, 2, 0, v);
`ifdef MAT_REG_FILE_DIAG_EN
        e = '0; e[15] = 32'h103;
        rd(RD_ROW, 3, 3, 0, e);
        e = '0; e[2] = 32'h100;
        rd(RD_ROW, 3, 0, 0, e);
        rd(RD_DIAG, 3, 2, 0, v);
`else
        rd(RD_ROW, 3, 3, 0, '0);
        rd(RD_ROW, 3, 0, 0, '0);
        rd(RD_DIAG, 3, 2, 0, '0);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("reads_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
